// File: rtl/branch_resolve_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : branch_resolve_queue_if                                      |
// | Description : Bundle of IF-stage prediction, MEM-stage resolution and      |
// |               fetch-redirect signals for branch_resolve_queue.             |
// |               slave  : seen by the queue (inputs in, results out)          |
// |               master : seen by the pipeline/driver side                    |
// | Signals     : stall, if_pc, if_cf, pred_taken, pred_target, mem_cf,        |
// |               mem_is_br, mem_pc, br_en, mem_target -> queue                |
// |               next_pc, flush, q_full, q_err, n_branches, n_mispredicts <-  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface branch_resolve_queue_if #(
  parameter int CNT_W = 32
) ();
  logic             stall;
  logic [31:0]      if_pc;
  logic             if_cf;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             mem_cf;
  logic             mem_is_br;
  logic [31:0]      mem_pc;
  logic             br_en;
  logic [31:0]      mem_target;
  logic [31:0]      next_pc;
  logic             flush;
  logic             q_full;
  logic             q_err;
  logic [CNT_W-1:0] n_branches;
  logic [CNT_W-1:0] n_mispredicts;

  modport slave (
    input  stall, if_pc, if_cf, pred_taken, pred_target,
           mem_cf, mem_is_br, mem_pc, br_en, mem_target,
    output next_pc, flush, q_full, q_err, n_branches, n_mispredicts
  );

  modport master (
    output stall, if_pc, if_cf, pred_taken, pred_target,
           mem_cf, mem_is_br, mem_pc, br_en, mem_target,
    input  next_pc, flush, q_full, q_err, n_branches, n_mispredicts
  );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : branch_resolve_queue                                         |
// | Description : In-order queue of IF-stage predictions {taken, target}.      |
// |               The head entry is compared with the MEM-stage outcome to     |
// |               produce the mispredict flush, the redirect PC and the fetch  |
// |               next-PC selection. Saturating branch/mispredict counters.    |
// | Ports       : clk  - clock (rising edge)                                   |
// |               rst  - asynchronous active-high reset                        |
// |               bus  - branch_resolve_queue_if.slave (see interface file)    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  wire logic               clk,
  input  wire logic               rst,
  branch_resolve_queue_if.slave   bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_BITS = PTR_W + 1;
  localparam logic [CNT_BITS-1:0] c_full_cnt = CNT_BITS'(DEPTH);

  // Prediction storage, circular; pointers wrap naturally since DEPTH is 2^n.
  logic              taken_q  [DEPTH];
  logic [31:0]       target_q [DEPTH];
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic              q_err_q, q_err_d;
  logic [CNT_W-1:0]  n_br_q, n_br_d;
  logic [CNT_W-1:0]  n_mis_q, n_mis_d;

  logic        w_full;
  logic        w_deq;
  logic        w_deq_valid;
  logic        w_act_taken;
  logic        w_head_taken;
  logic [31:0] w_head_target;
  logic        w_mispred;
  logic        w_enq;
  logic [31:0] w_redirect;

  assign w_full        = (count_q == c_full_cnt);
  assign w_deq         = bus.mem_cf & ~bus.stall;
  // A dequeue against an empty queue has no prediction to compare with;
  // it only raises the sticky error and must not flush or count.
  assign w_deq_valid   = w_deq & (count_q != '0);
  assign w_head_taken  = taken_q[rd_q];
  assign w_head_target = target_q[rd_q];
  assign w_act_taken   = bus.mem_is_br ? bus.br_en : 1'b1;
  assign w_mispred     = w_deq_valid &
                         ((w_act_taken != w_head_taken) |
                          (w_act_taken & (w_head_target != bus.mem_target)));
  // Fetch on the wrong path during a flush must not be recorded.
  assign w_enq         = bus.if_cf & ~bus.stall & ~w_mispred & ~w_full;
  assign w_redirect    = w_act_taken ? bus.mem_target : (bus.mem_pc + 32'd4);

  always_comb begin
    bus.next_pc = bus.if_pc + 32'd4;
    if (w_mispred) begin
      bus.next_pc = w_redirect;
    end else if (bus.if_cf & bus.pred_taken & ~w_full) begin
      bus.next_pc = bus.pred_target;
    end
  end

  assign bus.flush         = w_mispred;
  assign bus.q_full        = w_full;
  assign bus.q_err         = q_err_q;
  assign bus.n_branches    = n_br_q;
  assign bus.n_mispredicts = n_mis_q;

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    q_err_d = q_err_q | (w_deq & (count_q == '0));
    n_br_d  = n_br_q;
    n_mis_d = n_mis_q;

    if (w_deq_valid && (n_br_q != '1)) begin
      n_br_d = n_br_q + 1'b1;
    end
    if (w_mispred && (n_mis_q != '1)) begin
      n_mis_d = n_mis_q + 1'b1;
    end

    if (w_mispred) begin
      // Everything younger than the mispredicted instruction is wrong-path.
      count_d = '0;
      rd_d    = wr_q;
    end else begin
      if (w_deq_valid) begin
        rd_d = rd_q + 1'b1;
      end
      if (w_enq) begin
        wr_d = wr_q + 1'b1;
      end
      case ({w_enq, w_deq_valid})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      q_err_q <= 1'b0;
      n_br_q  <= '0;
      n_mis_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        taken_q[i]  <= 1'b0;
        target_q[i] <= '0;
      end
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      q_err_q <= q_err_d;
      n_br_q  <= n_br_d;
      n_mis_q <= n_mis_d;
      if (w_enq) begin
        taken_q[wr_q]  <= bus.pred_taken;
        target_q[wr_q] <= bus.pred_target;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_branch_resolve_queue                                      |
// | Description : Self-checking bench for branch_resolve_queue. A queue-based  |
// |               reference model predicts flush/next_pc/q_full/q_err and the  |
// |               counters every cycle; directed steps then random traffic.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_branch_resolve_queue;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_queue_if #(.CNT_W(32)) bif ();

  branch_resolve_queue #(.DEPTH(4), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [32:0] mq [$];
  logic        m_err;
  logic [31:0] m_nb, m_nm;

  // Model predictions for the current cycle
  logic        e_mis, e_dv, e_enq, e_full, e_errset;
  logic [31:0] e_npc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic icf, input logic [31:0] ipc,
                       input logic pt, input logic [31:0] ptgt,
                       input logic mcf, input logic mbr, input logic [31:0] mpc,
                       input logic ben, input logic [31:0] mtgt);
    bif.stall       = st;
    bif.if_cf       = icf;
    bif.if_pc       = ipc;
    bif.pred_taken  = pt;
    bif.pred_target = ptgt;
    bif.mem_cf      = mcf;
    bif.mem_is_br   = mbr;
    bif.mem_pc      = mpc;
    bif.br_en       = ben;
    bif.mem_target  = mtgt;
  endtask

  task automatic model_eval();
    logic act;
    e_full   = (mq.size() == 4);
    e_dv     = bif.mem_cf && !bif.stall && (mq.size() != 0);
    e_errset = bif.mem_cf && !bif.stall && (mq.size() == 0);
    act      = bif.mem_is_br ? bif.br_en : 1'b1;
    e_mis    = 1'b0;
    if (e_dv) begin
      e_mis = (act != mq[0][32]) || (act && (mq[0][31:0] != bif.mem_target));
    end
    if (e_mis)
      e_npc = act ? bif.mem_target : bif.mem_pc + 32'd4;
    else if (bif.if_cf && bif.pred_taken && !e_full)
      e_npc = bif.pred_target;
    else
      e_npc = bif.if_pc + 32'd4;
    e_enq = bif.if_cf && !bif.stall && !e_mis && !e_full;
  endtask

  // Settle, check all outputs against the model, clock, update the model.
  task automatic cycle();
    #1;
    model_eval();
    chk("flush",   {31'd0, bif.flush},  {31'd0, e_mis});
    chk("next_pc", bif.next_pc,         e_npc);
    chk("q_full",  {31'd0, bif.q_full}, {31'd0, e_full});
    chk("q_err",   {31'd0, bif.q_err},  {31'd0, m_err});
    chk("n_br",    bif.n_branches,      m_nb);
    chk("n_mis",   bif.n_mispredicts,   m_nm);
    @(posedge clk);
    if (e_errset) m_err = 1'b1;
    if (e_dv && m_nb != 32'hFFFF_FFFF) m_nb++;
    if (e_mis && m_nm != 32'hFFFF_FFFF) m_nm++;
    if (e_mis) begin
      mq.delete();
    end else begin
      if (e_dv) void'(mq.pop_front());
      if (e_enq) mq.push_back({bif.pred_taken, bif.pred_target});
    end
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0000_1000, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_err = 1'b0;
    m_nb  = 32'd0;
    m_nm  = 32'd0;
  endtask

  task automatic rand_step();
    logic [31:0] mt;
    mt = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    if (mq.size() != 0 && $urandom_range(0, 3) != 0) mt = mq[0][31:0];
    drive($urandom_range(0, 6) == 0, $urandom_range(0, 1) == 1,
          {20'd0, 10'($urandom), 2'b00},
          $urandom_range(0, 1) == 1, {22'd0, 8'($urandom_range(0, 255)), 2'b00},
          $urandom_range(0, 4) < 2, $urandom_range(0, 1) == 1,
          {20'd0, 10'($urandom), 2'b00}, $urandom_range(0, 1) == 1, mt);
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_flush",  {31'd0, bif.flush},  32'd0);
    chk("rst_full",   {31'd0, bif.q_full}, 32'd0);
    chk("rst_err",    {31'd0, bif.q_err},  32'd0);
    chk("rst_nbr",    bif.n_branches,      32'd0);
    chk("rst_nmis",   bif.n_mispredicts,   32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: branch predicted not-taken, resolves not-taken
    drive(0, 1, 32'h100, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    cycle();
    drive(0, 0, 32'h104, 0, 32'h0, 1, 1, 32'h100, 0, 32'h0);
    #1;
    chk("t1_flush", {31'd0, bif.flush}, 32'd0);
    chk("t1_npc",   bif.next_pc,        32'h108);
    cycle();
    idle();
    #1;
    chk("t1_nbr", bif.n_branches, 32'd1);
    cycle();

    // 2: predicted taken to 0x200, resolves not-taken
    drive(0, 1, 32'h100, 1, 32'h200, 0, 0, 32'h0, 0, 32'h0);
    #1;
    chk("t2_pred_npc", bif.next_pc, 32'h200);
    cycle();
    drive(0, 0, 32'h200, 0, 32'h0, 1, 1, 32'h100, 0, 32'h0);
    #1;
    chk("t2_flush", {31'd0, bif.flush}, 32'd1);
    chk("t2_npc",   bif.next_pc,        32'h104);
    cycle();

    // 3: jal predicted to 0x300, actual target 0x340
    drive(0, 1, 32'h180, 1, 32'h300, 0, 0, 32'h0, 0, 32'h0);
    cycle();
    drive(0, 0, 32'h300, 0, 32'h0, 1, 0, 32'h180, 0, 32'h340);
    #1;
    chk("t3_flush", {31'd0, bif.flush}, 32'd1);
    chk("t3_npc",   bif.next_pc,        32'h340);
    cycle();
    idle();
    #1;
    chk("t3_nmis", bif.n_mispredicts, 32'd2);
    cycle();

    // 4: fill, overflow attempt, deq, enq+deq, drain in order
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 32'h400 + 32'(i * 4), 1, 32'h1000 + 32'(i * 16), 0, 0, 32'h0, 0, 32'h0);
      cycle();
    end
    drive(0, 1, 32'h410, 1, 32'h2000, 0, 0, 32'h0, 0, 32'h0);
    #1;
    chk("t4_full",     {31'd0, bif.q_full}, 32'd1);
    chk("t4_full_npc", bif.next_pc,         32'h414);
    cycle();
    drive(0, 0, 32'h410, 0, 32'h0, 1, 0, 32'h400, 0, 32'h1000);
    cycle();
    drive(0, 1, 32'h420, 1, 32'h1040, 1, 0, 32'h404, 0, 32'h1010);
    cycle();
    drive(0, 1, 32'h424, 1, 32'h1050, 1, 0, 32'h408, 0, 32'h1020);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'h500, 0, 32'h0, 1, 0, 32'h0, 0, 32'h1030 + 32'(i * 16));
      #1;
      chk("t4_order", {31'd0, bif.flush}, 32'd0);
      cycle();
    end

    // 5: dequeue from empty queue
    drive(0, 0, 32'h600, 0, 32'h0, 1, 1, 32'h600, 1, 32'h700);
    #1;
    chk("t5_flush", {31'd0, bif.flush}, 32'd0);
    cycle();
    idle();
    cycle();
    cycle();
    #1;
    chk("t5_sticky", {31'd0, bif.q_err}, 32'd1);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) rand_step();

    // 6: async reset with entries held under stall
    rst = 1'b0;
    idle();
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'h800, 1, 32'h900 + 32'(i * 4), 0, 0, 32'h0, 0, 32'h0);
      cycle();
    end
    drive(1, 0, 32'h800, 0, 32'h0, 1, 1, 32'h0, 1, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_full",  {31'd0, bif.q_full}, 32'd0);
    chk("t6_flush", {31'd0, bif.flush},  32'd0);
    chk("t6_err",   {31'd0, bif.q_err},  32'd0);
    chk("t6_nbr",   bif.n_branches,      32'd0);
    chk("t6_nmis",  bif.n_mispredicts,   32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle();
    for (int n = 0; n < 200; n++) rand_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
